// File: rtl/doorlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : doorlock_ctrl
// Brief    : Four-digit keypad door lock with lockout and reprogrammable code.
// Revision : 1.0
// ============================================================================
module doorlock_ctrl #(
    parameter int          OPEN_TIME = 16,
    parameter int          LOCK_TIME = 32,
    parameter int          MAX_FAIL  = 3,
    parameter logic [15:0] RESET_PW  = 16'h1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig3,
    input  logic [3:0] dig2,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    input  logic       key,
    input  logic       enter,
    input  logic       prog,
    output logic       unlock,
    output logic       alarm,
    output logic       err,
    output logic [1:0] fail_cnt,
    output logic [2:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR  = 2'd1,
        ST_OPEN = 2'd2,
        ST_LOCK = 2'd3
    } state_t;

    localparam int              c_tmax      = (OPEN_TIME > LOCK_TIME) ? OPEN_TIME : LOCK_TIME;
    localparam int              c_tw        = (c_tmax < 2) ? 1 : $clog2(c_tmax);
    localparam logic [c_tw-1:0] c_open_last = c_tw'(OPEN_TIME - 1);
    localparam logic [c_tw-1:0] c_lock_last = c_tw'(LOCK_TIME - 1);
    localparam logic [1:0]      c_max_fail  = 2'(MAX_FAIL);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_pw;
    logic [1:0]        r_fail;
    logic [2:0]        r_ndig;
    logic [c_tw-1:0]   r_timer;
    logic              r_key_q;
    logic              r_enter_q;
    logic              r_unlock;
    logic              r_alarm;
    logic              r_err;

    logic              w_key_rise;
    logic              w_ent_rise;
    logic [15:0]       w_code;
    logic              w_full;
    logic              w_state_chg;
    logic              w_pw_load;
    logic [1:0]        w_fail_inc;

    assign w_key_rise  = key & ~r_key_q;
    assign w_ent_rise  = enter & ~r_enter_q;
    assign w_code      = {dig3, dig2, dig1, dig0};
    assign w_full      = (r_ndig == 3'd4);
    assign w_state_chg = (w_next != r_state);
    assign w_fail_inc  = (r_fail == 2'd3) ? 2'd3 : r_fail + 2'd1;

    always_comb begin
        w_next    = r_state;
        w_pw_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ent_rise) begin
                    w_next = (w_full && (w_code == r_pw)) ? ST_OPEN : ST_ERR;
                end
            end
            ST_ERR: begin
                w_next = (w_fail_inc >= c_max_fail) ? ST_LOCK : ST_IDLE;
            end
            ST_OPEN: begin
                // A programming request ends the open window immediately.
                if (w_ent_rise && prog && w_full) begin
                    w_pw_load = 1'b1;
                    w_next    = ST_IDLE;
                end else if (r_timer == c_open_last) begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (r_timer == c_lock_last) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pw      <= RESET_PW;
            r_fail    <= 2'd0;
            r_ndig    <= 3'd0;
            r_timer   <= '0;
            r_key_q   <= 1'b0;
            r_enter_q <= 1'b0;
            r_unlock  <= 1'b0;
            r_alarm   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_key_q   <= key;
            r_enter_q <= enter;
            r_unlock  <= (w_next == ST_OPEN);
            r_alarm   <= (w_next == ST_LOCK);
            r_err     <= (w_next == ST_ERR);

            if (w_pw_load) begin
                r_pw <= w_code;
            end

            if (r_state == ST_ERR) begin
                r_fail <= w_fail_inc;
            end else if ((w_next == ST_OPEN) && (r_state != ST_OPEN)) begin
                r_fail <= 2'd0;
            end else if ((r_state == ST_LOCK) && (w_next == ST_IDLE)) begin
                r_fail <= 2'd0;
            end

            // Enter takes priority over a coincident digit key.
            if (w_state_chg || w_ent_rise) begin
                r_ndig <= 3'd0;
            end else if (w_key_rise && !w_full &&
                         ((r_state == ST_IDLE) || (r_state == ST_OPEN))) begin
                r_ndig <= r_ndig + 3'd1;
            end

            if (w_state_chg) begin
                r_timer <= '0;
            end else if ((r_state == ST_OPEN) || (r_state == ST_LOCK)) begin
                r_timer <= r_timer + c_tw'(1);
            end
        end
    end

    assign unlock   = r_unlock;
    assign alarm    = r_alarm;
    assign err      = r_err;
    assign fail_cnt = r_fail;
    assign state    = {1'b0, r_state};

endmodule
`default_nettype wire
